// File: rtl/slot_counter.sv
// ---------------------------------------------------------------------------
// slot_counter
//
// Tracks free parking slots for two independent areas (normal and
// handicapped), drives a timed barrier-open command for each area and flags
// refused entries and impossible exits.
//
// Ports:
//   clk                 - single clock, all state changes on its rising edge
//   rst                 - synchronous, active-high reset
//   entry_normal        - raw (asynchronous) entry sensor, normal area
//   exit_normal         - raw (asynchronous) exit sensor, normal area
//   entry_handicapped   - raw (asynchronous) entry sensor, handicapped area
//   exit_handicapped    - raw (asynchronous) exit sensor, handicapped area
//   slots_normal        - registered free-slot count, normal area
//   slots_handicapped   - registered free-slot count, handicapped area
//   gate_normal         - registered barrier-open command, normal area
//   gate_handicapped    - registered barrier-open command, handicapped area
//   reject_normal       - one-cycle pulse: entry refused, normal area full
//   reject_handicapped  - one-cycle pulse: entry refused, handicapped area full
//   err                 - one-cycle pulse: exit seen while an area was empty
//                         of cars (count already at capacity), either area
// ---------------------------------------------------------------------------
module slot_counter #(
    parameter int unsigned CAP_NORMAL      = 20,
    parameter int unsigned CAP_HANDICAPPED = 4,
    parameter int unsigned GATE_CYCLES     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_normal,
    input  logic       exit_normal,
    input  logic       entry_handicapped,
    input  logic       exit_handicapped,
    output logic [4:0] slots_normal,
    output logic [4:0] slots_handicapped,
    output logic       gate_normal,
    output logic       gate_handicapped,
    output logic       reject_normal,
    output logic       reject_handicapped,
    output logic       err
);

    typedef enum logic {
        CLOSED,
        OPEN
    } gate_state_t;

    localparam logic [7:0] GATE_LOAD = 8'(GATE_CYCLES);

    // Sensor bit order: [0] entry_normal, [1] exit_normal,
    //                   [2] entry_handicapped, [3] exit_handicapped.
    // Area a uses bit 2a for entry and bit 2a+1 for exit.
    logic [3:0] sensor_raw;
    logic [3:0] sync_a;
    logic [3:0] sync_b;
    logic [3:0] sync_prev;
    logic [3:0] sensor_event;

    assign sensor_raw = {exit_handicapped, entry_handicapped, exit_normal, entry_normal};

    // Two-flop synchronizer per sensor, followed by a third flop holding the
    // previous synchronized level. Clearing every stage on reset means a
    // sensor held high across reset release still looks like a fresh rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a    <= '0;
            sync_b    <= '0;
            sync_prev <= '0;
        end else begin
            sync_a    <= sensor_raw;
            sync_b    <= sync_a;
            sync_prev <= sync_b;
        end
    end

    // An event is a rising edge of the synchronized level: exactly one
    // cycle per sensor assertion no matter how long it is held.
    assign sensor_event = sync_b & ~sync_prev;

    for (genvar a = 0; a < 2; a++) begin : g_area
        localparam logic [4:0] CAP = (a == 0) ? 5'(CAP_NORMAL) : 5'(CAP_HANDICAPPED);

        logic        ent;
        logic        ext;
        logic        accept;
        logic [4:0]  count_q;
        logic [4:0]  count_d;
        gate_state_t state_q;
        gate_state_t state_d;
        logic [7:0]  timer_q;
        logic [7:0]  timer_d;
        logic        gate_q;
        logic        reject_q;
        logic        reject_d;
        logic        err_q;
        logic        err_d;

        assign ent = sensor_event[2*a];
        assign ext = sensor_event[2*a+1];

        // Slot accounting and gate FSM next state. A simultaneous entry and
        // exit cancel out on the count but the entering car is still let in,
        // even when the area looks full or empty. Otherwise an entry needs a
        // free slot and an exit needs an occupied one; an impossible request
        // leaves the count alone and raises reject or err instead.
        always_comb begin
            count_d  = count_q;
            state_d  = state_q;
            timer_d  = timer_q;
            accept   = 1'b0;
            reject_d = 1'b0;
            err_d    = 1'b0;

            if (ent && ext) begin
                accept = 1'b1;
            end else if (ent) begin
                if (count_q != 5'd0) begin
                    accept  = 1'b1;
                    count_d = count_q - 5'd1;
                end else begin
                    reject_d = 1'b1;
                end
            end else if (ext) begin
                if (count_q < CAP) begin
                    count_d = count_q + 5'd1;
                end else begin
                    err_d = 1'b1;
                end
            end

            // The timer holds the number of open cycles still to come,
            // including the current one; closing on the edge after it
            // reads 1 keeps the gate high for exactly GATE_CYCLES cycles.
            // A new car while open simply restarts the window.
            case (state_q)
                CLOSED: begin
                    if (accept) begin
                        state_d = OPEN;
                        timer_d = GATE_LOAD;
                    end
                end
                OPEN: begin
                    if (accept) begin
                        timer_d = GATE_LOAD;
                    end else if (timer_q <= 8'd1) begin
                        state_d = CLOSED;
                        timer_d = 8'd0;
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
                default: begin
                    state_d = CLOSED;
                    timer_d = 8'd0;
                end
            endcase
        end

        // Area state registers. The gate output is registered from the next
        // state so it rises in the same cycle the count changes.
        always_ff @(posedge clk) begin
            if (rst) begin
                count_q  <= CAP;
                state_q  <= CLOSED;
                timer_q  <= 8'd0;
                gate_q   <= 1'b0;
                reject_q <= 1'b0;
                err_q    <= 1'b0;
            end else begin
                count_q  <= count_d;
                state_q  <= state_d;
                timer_q  <= timer_d;
                gate_q   <= (state_d == OPEN);
                reject_q <= reject_d;
                err_q    <= err_d;
            end
        end
    end

    assign slots_normal       = g_area[0].count_q;
    assign slots_handicapped  = g_area[1].count_q;
    assign gate_normal        = g_area[0].gate_q;
    assign gate_handicapped   = g_area[1].gate_q;
    assign reject_normal      = g_area[0].reject_q;
    assign reject_handicapped = g_area[1].reject_q;
    assign err                = g_area[0].err_q | g_area[1].err_q;

endmodule

// File: tb/tb_slot_counter.sv
// ---------------------------------------------------------------------------
// tb_slot_counter
//
// Self-checking bench for slot_counter: a table of per-cycle vectors, a few
// hand-written multi-cycle scenarios, and a randomized run compared against
// a behavioural model of the parking rules.
// ---------------------------------------------------------------------------
module tb_slot_counter;

    localparam int CAP_N = 20;
    localparam int CAP_H = 4;
    localparam int GATE  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       entry_normal;
    logic       exit_normal;
    logic       entry_handicapped;
    logic       exit_handicapped;
    logic [4:0] slots_normal;
    logic [4:0] slots_handicapped;
    logic       gate_normal;
    logic       gate_handicapped;
    logic       reject_normal;
    logic       reject_handicapped;
    logic       err;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    slot_counter #(
        .CAP_NORMAL     (CAP_N),
        .CAP_HANDICAPPED(CAP_H),
        .GATE_CYCLES    (GATE)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .entry_normal      (entry_normal),
        .exit_normal       (exit_normal),
        .entry_handicapped (entry_handicapped),
        .exit_handicapped  (exit_handicapped),
        .slots_normal      (slots_normal),
        .slots_handicapped (slots_handicapped),
        .gate_normal       (gate_normal),
        .gate_handicapped  (gate_handicapped),
        .reject_normal     (reject_normal),
        .reject_handicapped(reject_handicapped),
        .err               (err)
    );

    // Behavioural model: a sensor event happens two edges after the level is
    // first sampled high (previous sample low); history restarts at reset.
    int  mCnt[2];
    int  mRem[2];
    bit  mRej[2];
    bit  mErr;
    bit  mHist[4][$];
    int  capOf[2] = '{CAP_N, CAP_H};

    task automatic modelStep(input bit r, input logic [3:0] raw);
        bit ev[4];
        int sz;
        bit ent, ext, accept;
        if (r) begin
            for (int a = 0; a < 2; a++) begin
                mCnt[a] = capOf[a];
                mRem[a] = 0;
                mRej[a] = 0;
            end
            mErr = 0;
            for (int s = 0; s < 4; s++) mHist[s].delete();
            return;
        end
        for (int s = 0; s < 4; s++) begin
            sz = mHist[s].size();
            ev[s] = (sz >= 2 && mHist[s][sz-2]) && !(sz >= 3 && mHist[s][sz-3]);
            mHist[s].push_back(raw[s]);
            while (mHist[s].size() > 3) void'(mHist[s].pop_front());
        end
        mErr = 0;
        for (int a = 0; a < 2; a++) begin
            ent = ev[2*a];
            ext = ev[2*a+1];
            accept = 0;
            mRej[a] = 0;
            if (ent && ext) accept = 1;
            else if (ent) begin
                if (mCnt[a] > 0) begin
                    mCnt[a]--;
                    accept = 1;
                end else mRej[a] = 1;
            end else if (ext) begin
                if (mCnt[a] < capOf[a]) mCnt[a]++;
                else mErr = 1;
            end
            if (accept) mRem[a] = GATE;
            else if (mRem[a] > 0) mRem[a]--;
        end
    endtask

    function automatic int packOut(int sn, int sh, logic gn, logic gh, logic rn, logic rh, logic er);
        return {17'd0, sn[4:0], sh[4:0], gn, gh, rn, rh, er};
    endfunction

    function automatic int dutOut();
        return packOut(int'(slots_normal), int'(slots_handicapped), gate_normal,
                       gate_handicapped, reject_normal, reject_handicapped, err);
    endfunction

    function automatic int modelOut();
        return packOut(mCnt[0], mCnt[1], mRem[0] > 0, mRem[1] > 0, mRej[0], mRej[1], mErr);
    endfunction

    // Drive one cycle of inputs, let the edge happen, advance the model.
    task automatic applyStimulus(input logic r, input logic en, input logic xn,
                                 input logic eh, input logic xh);
        rst               = r;
        entry_normal      = en;
        exit_normal       = xn;
        entry_handicapped = eh;
        exit_handicapped  = xh;
        @(posedge clk);
        #1;
        modelStep(r, {xh, eh, xn, en});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    typedef struct {
        logic r, en, xn, eh, xh;
        int   sn, sh;
        logic gn, gh, rn, rh, er;
    } vec_t;

    function automatic vec_t mkv(logic r, logic en, logic xn, logic eh, logic xh,
                                 int sn, int sh, logic gn, logic gh,
                                 logic rn, logic rh, logic er);
        vec_t v;
        v.r = r; v.en = en; v.xn = xn; v.eh = eh; v.xh = xh;
        v.sn = sn; v.sh = sh; v.gn = gn; v.gh = gh;
        v.rn = rn; v.rh = rh; v.er = er;
        return v;
    endfunction

    vec_t table_q[$];

    initial begin
        int p[4];
        logic [3:0] lvl;
        logic r;

        // Reset, single normal entry, then exit on a full handicapped area.
        table_q.push_back(mkv(1,0,0,0,0, 20,4, 0,0,0,0,0));
        table_q.push_back(mkv(0,1,0,0,0, 20,4, 0,0,0,0,0));
        table_q.push_back(mkv(0,0,0,0,0, 20,4, 0,0,0,0,0));
        for (int i = 0; i < 8; i++)
            table_q.push_back(mkv(0,0,0,0,0, 19,4, 1,0,0,0,0));
        table_q.push_back(mkv(0,0,0,0,0, 19,4, 0,0,0,0,0));
        table_q.push_back(mkv(0,0,0,0,0, 19,4, 0,0,0,0,0));
        table_q.push_back(mkv(1,0,0,0,0, 20,4, 0,0,0,0,0));
        table_q.push_back(mkv(0,0,0,0,1, 20,4, 0,0,0,0,0));
        table_q.push_back(mkv(0,0,0,0,1, 20,4, 0,0,0,0,0));
        table_q.push_back(mkv(0,0,0,0,0, 20,4, 0,0,0,0,1));
        table_q.push_back(mkv(0,0,0,0,0, 20,4, 0,0,0,0,0));
        table_q.push_back(mkv(0,0,0,0,0, 20,4, 0,0,0,0,0));

        foreach (table_q[i]) begin
            applyStimulus(table_q[i].r, table_q[i].en, table_q[i].xn,
                          table_q[i].eh, table_q[i].xh);
            checkOutput($sformatf("table[%0d]", i), dutOut(),
                        packOut(table_q[i].sn, table_q[i].sh, table_q[i].gn, table_q[i].gh,
                                table_q[i].rn, table_q[i].rh, table_q[i].er));
        end

        // Fill the handicapped area, then a fifth car is refused.
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 1, 0);
            applyStimulus(0, 0, 0, 0, 0);
        end
        idle(10);
        checkOutput("hc_full_slots", int'(slots_handicapped), 0);
        checkOutput("hc_full_gate", int'(gate_handicapped), 0);
        checkOutput("hc_normal_untouched", int'(slots_normal), CAP_N);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("hc_rej_k", int'(reject_handicapped), 0);
        idle(1);
        checkOutput("hc_rej_k1", int'(reject_handicapped), 0);
        idle(1);
        checkOutput("hc_rej_k2", int'(reject_handicapped), 1);
        checkOutput("hc_rej_slots", int'(slots_handicapped), 0);
        checkOutput("hc_rej_gate", int'(gate_handicapped), 0);
        idle(1);
        checkOutput("hc_rej_k3", int'(reject_handicapped), 0);
        idle(3);
        checkOutput("hc_rej_gate_later", int'(gate_handicapped), 0);

        // Simultaneous entry and exit at a full (zero free) normal area.
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < CAP_N; i++) begin
            applyStimulus(0, 1, 0, 0, 0);
            applyStimulus(0, 0, 0, 0, 0);
        end
        idle(12);
        checkOutput("nz_slots", int'(slots_normal), 0);
        checkOutput("nz_gate_closed", int'(gate_normal), 0);
        applyStimulus(0, 1, 1, 0, 0);
        idle(2);
        checkOutput("nz_both_slots", int'(slots_normal), 0);
        checkOutput("nz_both_gate", int'(gate_normal), 1);
        checkOutput("nz_both_rej", int'(reject_normal), 0);
        checkOutput("nz_both_err", int'(err), 0);
        idle(1);
        checkOutput("nz_both_rej_next", int'(reject_normal), 0);
        checkOutput("nz_both_err_next", int'(err), 0);
        idle(6);
        checkOutput("nz_gate_last", int'(gate_normal), 1);
        idle(1);
        checkOutput("nz_gate_closed_after", int'(gate_normal), 0);

        // Simultaneous entry and exit at capacity: no err, gate opens.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        idle(2);
        checkOutput("cap_both_slots", int'(slots_normal), CAP_N);
        checkOutput("cap_both_gate", int'(gate_normal), 1);
        checkOutput("cap_both_err", int'(err), 0);

        // Second entry five cycles into an open gate extends it.
        applyStimulus(1, 0, 0, 0, 0);
        for (int e = 1; e <= 17; e++) begin
            applyStimulus(0, (e == 1 || e == 6), 0, 0, 0);
            checkOutput($sformatf("ext_gate_e%0d", e), int'(gate_normal),
                        (e >= 3 && e <= 15) ? 1 : 0);
            checkOutput($sformatf("ext_slots_e%0d", e), int'(slots_normal),
                        (e < 3) ? 20 : (e < 8) ? 19 : 18);
        end

        // Reset mid-gate at 15 free, with a sensor held high across release.
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0, 0, 0);
            applyStimulus(0, 0, 0, 0, 0);
        end
        idle(1);
        checkOutput("rm_slots_before", int'(slots_normal), 15);
        checkOutput("rm_gate_before", int'(gate_normal), 1);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("rm_slots_reset", int'(slots_normal), CAP_N);
        checkOutput("rm_gate_reset", int'(gate_normal), 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("rm_slots_k1", int'(slots_normal), CAP_N);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("rm_slots_k2", int'(slots_normal), CAP_N - 1);
        checkOutput("rm_gate_k2", int'(gate_normal), 1);
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0, 0);
        idle(3);
        checkOutput("rm_slots_held", int'(slots_normal), CAP_N - 1);

        // Randomized traffic against the behavioural model.
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("rand_reset", dutOut(), modelOut());
        for (int c = 0; c < 4000; c++) begin
            if (c % 400 == 0)
                for (int s = 0; s < 4; s++) p[s] = $urandom_range(5, 60);
            for (int s = 0; s < 4; s++) lvl[s] = ($urandom_range(0, 99) < p[s]);
            r = ($urandom_range(0, 299) == 0);
            applyStimulus(r, lvl[0], lvl[1], lvl[2], lvl[3]);
            checkOutput($sformatf("random_c%0d", c), dutOut(), modelOut());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
